// File: rtl/lc3_decode_pkg.sv
// rtl/lc3_decode_pkg.sv - LC-3 decode stage shared types and encodings
package lc3_decode_pkg;

  localparam int LC3_W = 16;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef logic [1:0] w_ctrl_t;
  typedef logic [5:0] e_ctrl_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_BASE = 2'b11;

  localparam w_ctrl_t W_ALU = 2'b00;
  localparam w_ctrl_t W_LEA = 2'b01;
  localparam w_ctrl_t W_MEM = 2'b10;

  typedef struct packed {
    w_ctrl_t          w;
    logic             mem;
    e_ctrl_t          e;
    logic [LC3_W-1:0] ir;
    logic [LC3_W-1:0] npc;
    logic             illegal;
  } dec_bundle_t;

endpackage

// File: rtl/lc3_decode_lut.sv
// rtl/lc3_decode_lut.sv - combinational LC-3 opcode to control-field decode
module lc3_decode_lut
  import lc3_decode_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_imm,
  output logic [1:0] o_w,
  output logic       o_mem,
  output logic [5:0] o_e,
  output logic       o_illegal
);

  logic [1:0] w_alu;
  logic [1:0] w_pc1;
  logic       w_pc2;
  logic       w_op2;

  always_comb begin
    w_alu     = ALU_ADD;
    w_pc1     = PC1_NONE;
    w_pc2     = 1'b0;
    w_op2     = 1'b0;
    o_w       = W_ALU;
    o_mem     = 1'b0;
    o_illegal = 1'b0;
    case (opcode_e'(i_opcode))
      OP_ADD: begin w_alu = ALU_ADD; w_op2 = ~i_imm; end
      OP_AND: begin w_alu = ALU_AND; w_op2 = ~i_imm; end
      OP_NOT: w_alu = ALU_NOT;
      OP_BR:  begin w_pc1 = PC1_OFF9; w_pc2 = 1'b1; end
      OP_JMP: w_pc1 = PC1_BASE;
      OP_LD:  begin w_pc1 = PC1_OFF9; w_pc2 = 1'b1; o_w = W_MEM; end
      OP_LDI: begin w_pc1 = PC1_OFF9; w_pc2 = 1'b1; o_w = W_MEM; o_mem = 1'b1; end
      OP_ST:  begin w_pc1 = PC1_OFF9; w_pc2 = 1'b1; end
      OP_STI: begin w_pc1 = PC1_OFF9; w_pc2 = 1'b1; o_mem = 1'b1; end
      OP_LEA: begin w_pc1 = PC1_OFF9; w_pc2 = 1'b1; o_w = W_LEA; end
      OP_LDR: begin w_pc1 = PC1_OFF6; o_w = W_MEM; end
      OP_STR: w_pc1 = PC1_OFF6;
      OP_JSR, OP_RTI, OP_RES, OP_TRAP: o_illegal = 1'b1;
      default: ;
    endcase
  end

  assign o_e = {w_alu, w_pc1, w_pc2, w_op2};

endmodule

// File: rtl/decode_stage_q.sv
// rtl/decode_stage_q.sv - LC-3 decode stage with in-order output queue
module decode_stage_q
  import lc3_decode_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 2,
  parameter int FLAG_ILLEGAL = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      instr_dout,
  input  logic [DATA_W-1:0]      npc_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             W_control_o,
  output logic                   Mem_control_o,
  output logic [5:0]             E_control_o,
  output logic [DATA_W-1:0]      IR_o,
  output logic [DATA_W-1:0]      npc_o,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dec_bundle_t      r_mem [DEPTH];
  dec_bundle_t      r_last;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]  w_dec_w;
  logic        w_dec_mem;
  logic [5:0]  w_dec_e;
  logic        w_dec_illegal;
  dec_bundle_t w_entry;
  dec_bundle_t w_head;
  logic        w_push;
  logic        w_pop;

  lc3_decode_lut u_lut (
    .i_opcode  (instr_dout[15:12]),
    .i_imm     (instr_dout[5]),
    .o_w       (w_dec_w),
    .o_mem     (w_dec_mem),
    .o_e       (w_dec_e),
    .o_illegal (w_dec_illegal)
  );

  always_comb begin
    w_entry         = '0;
    w_entry.w       = w_dec_w;
    w_entry.mem     = w_dec_mem;
    w_entry.e       = w_dec_e;
    w_entry.ir      = LC3_W'(instr_dout);
    w_entry.npc     = LC3_W'(npc_in);
    w_entry.illegal = w_dec_illegal;
  end

  assign in_ready  = (r_count < CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // r_last keeps the most recently shown head so an empty queue holds its outputs
  assign w_head = out_valid ? r_mem[r_rd_ptr] : r_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_last   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      if (out_valid) r_last <= r_mem[r_rd_ptr];
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign W_control_o   = w_head.w;
  assign Mem_control_o = w_head.mem;
  assign E_control_o   = w_head.e;
  assign IR_o          = DATA_W'(w_head.ir);
  assign npc_o         = DATA_W'(w_head.npc);
  assign out_illegal   = (FLAG_ILLEGAL != 0) ? w_head.illegal : 1'b0;
  assign count_o       = r_count;

endmodule

// File: doc/decode_stage_q.md
Name: decode_stage_q

Overview:
Parametrised LC-3 decode stage with valid/ready handshakes on both sides. It accepts a fetched instruction plus its next-PC and decodes the opcode into W_control, Mem_control and E_control. The decoded bundle is buffered in a DEPTH-entry in-order queue so that fetch and execute are decoupled. It sits between the fetch stage and the execute stage and adds backpressure, flush and illegal-opcode flagging, none of which the single-register decode has.

Parameters:
DATA_W, 16, width of instruction and npc
DEPTH, 2, output queue entries; power of two, >=2
FLAG_ILLEGAL, 1, 1 = drive out_illegal for reserved opcodes; 0 = out_illegal tied 0

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept (queue not full)
instr_dout  input  DATA_W  fetched instruction; opcode = [15:12]
npc_in  input  DATA_W  PC+1 of the instruction
flush  input  1  synchronous discard of all queued entries
out_valid  output  1  queue head valid
out_ready  input  1  execute accepts head
W_control_o  output  2  writeback select
Mem_control_o  output  1  indirect memory access
E_control_o  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
IR_o  output  DATA_W  queued instruction
npc_o  output  DATA_W  queued npc
out_illegal  output  1  head holds a reserved opcode (1000, 1101, 1111, 0100)
count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous): queue emptied, rd/wr pointers 0, count_o=0, out_valid=0. All data outputs 0: W/Mem/E, IR_o, npc_o, out_illegal. Release is synchronous to clock.
- in_ready = (count < DEPTH). It depends only on registered state: no combinational path from out_ready.
- Push when in_valid & in_ready. Pop when out_valid & out_ready. Both may happen in the same cycle; count then stays unchanged.
- Decode is combinational at the input. The decoded bundle is written into the queue on push.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1 when the queue was empty.
- Outputs are driven from the queue head. When empty, out_valid=0 and the data outputs hold their last value (0 after reset).
- Decode table:
  - ADD: alu=00, op2select = ~instr[5].
  - AND: alu=01, op2select = ~instr[5].
  - NOT: alu=10, op2select=0.
  - BR: pcselect1=01, pcselect2=1.
  - JMP: pcselect1=11, pcselect2=0.
  - LD, LDI, ST, STI, LEA: pcselect1=01, pcselect2=1.
  - LDR, STR: pcselect1=10, pcselect2=0.
  - Every field not listed above is 0.
  - W_control: 00 for ALU ops, 01 for LEA, 10 for LD/LDR/LDI, 00 for all others.
  - Mem_control = 1 only for LDI and STI.
  - Reserved opcodes: all controls 0, illegal=1 (masked by FLAG_ILLEGAL).
- flush=1: at the next edge the queue is emptied and count=0. Flush has priority over a simultaneous push and pop, so an instruction presented in the flush cycle is dropped.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH, and no pop is performed when empty.
- Asserting reset mid-stream discards all entries immediately. The outputs go to their reset values without waiting for a clock edge.

Decomposition:
- Shared package lc3_decode_pkg contains:
  - opcode enum (4-bit);
  - typedefs w_ctrl_t (2), e_ctrl_t (6);
  - constants for the alu_control / pcselect1 encodings;
  - packed struct dec_bundle_t {w, mem, e, ir, npc, illegal}.
- One combinational sub-module, lc3_decode_lut: instr in, dec_bundle_t fields out.
- The queue is inline in decode_stage_q.

Test Plan:
- Reset, then push 0x1283 (ADD R1,R2,R3) with npc 0x3001 -> next cycle out_valid=1, E=6'b000001, W=00, Mem=0, IR_o=0x1283, npc_o=0x3001.
- Push 0xE005 (LEA) then 0xA602 (LDI), out_ready=1 -> heads in order: E=000110 W=01 Mem=0; then E=000110 W=10 Mem=1.
- Push 0xD000 -> out_illegal=1, controls all 0. Same with FLAG_ILLEGAL=0 -> out_illegal=0.
- DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after 2 accepted, count_o=2. Raise out_ready -> FIFO order preserved, third accepted on the first pop.
- Queue holding 2 entries; flush plus push in the same cycle -> count_o=0, out_valid=0, pushed instruction absent.
- Reset asserted between clock edges with 1 entry queued -> out_valid=0 and outputs 0 immediately, count_o=0.
